// File: rtl/hexpad_loader.sv
// rtl/hexpad_loader.sv - front-panel hex keypad debounce, byte assembly and memory write sequencer
module hexpad_loader #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int WRITE_CYCLES   = 2,
  parameter int AUTO_INC       = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clken,
  input  logic        prog,
  input  logic [15:0] key_value,
  input  logic        btn_next,
  input  logic        btn_prev,
  input  logic        btn_store,
  input  logic [7:0]  mem_rdata,
  output logic [3:0]  adr,
  output logic [7:0]  data,
  output logic        write,
  output logic [1:0]  digits,
  output logic        key_err
);

  localparam int KCW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int WCW = $clog2(WRITE_CYCLES + 1);
  localparam logic [KCW-1:0] K_LAST = KCW'(DEBOUNCE_TICKS - 1);
  localparam logic [WCW-1:0] W_LAST = WCW'(WRITE_CYCLES - 1);

  typedef enum logic [1:0] {KIDLE = 2'd0, KPRESS = 2'd1, KREL = 2'd2} kstate_e;
  typedef enum logic [1:0] {WIDLE = 2'd0, WSTORE = 2'd1, WLOAD = 2'd2} wstate_e;

  kstate_e        r_kstate, w_kstate_nxt;
  logic [KCW-1:0] r_kcnt, w_kcnt_nxt;
  logic [15:0]    r_klatch, w_klatch_nxt;
  wstate_e        r_wstate, w_wstate_nxt;
  logic [WCW-1:0] r_wcnt, w_wcnt_nxt;

  logic [3:0] r_adr;
  logic [7:0] r_data;
  logic [1:0] r_digits;
  logic       r_key_err;

  logic       w_key_act, w_store_done, w_step_next, w_step_prev, w_load;
  logic [3:0] w_nib;
  logic       w_onehot;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_kstate <= KIDLE;
      r_kcnt   <= '0;
      r_klatch <= '0;
      r_wstate <= WIDLE;
      r_wcnt   <= '0;
    end else begin
      r_kstate <= w_kstate_nxt;
      r_kcnt   <= w_kcnt_nxt;
      r_klatch <= w_klatch_nxt;
      r_wstate <= w_wstate_nxt;
      r_wcnt   <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_kstate_nxt = r_kstate;
    w_kcnt_nxt   = r_kcnt;
    w_klatch_nxt = r_klatch;
    if (!prog) begin
      w_kstate_nxt = KIDLE;
      w_kcnt_nxt   = '0;
    end else if (clken) begin
      case (r_kstate)
        KIDLE: if (key_value != '0) begin
          w_klatch_nxt = key_value;
          w_kcnt_nxt   = KCW'(1);
          w_kstate_nxt = KPRESS;
        end
        KPRESS: if (key_value != r_klatch) begin
          w_kstate_nxt = KIDLE;
          w_kcnt_nxt   = '0;
        end else if (r_kcnt == K_LAST) begin
          w_kstate_nxt = KREL;
          w_kcnt_nxt   = '0;
        end else begin
          w_kcnt_nxt = r_kcnt + KCW'(1);
        end
        KREL: if (key_value != '0) begin
          w_kcnt_nxt = '0;
        end else if (r_kcnt == K_LAST) begin
          w_kstate_nxt = KIDLE;
          w_kcnt_nxt   = '0;
        end else begin
          w_kcnt_nxt = r_kcnt + KCW'(1);
        end
        default: w_kstate_nxt = KIDLE;
      endcase
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wcnt_nxt   = r_wcnt;
    if (!prog) begin
      w_wstate_nxt = WIDLE;
      w_wcnt_nxt   = '0;
    end else begin
      case (r_wstate)
        WIDLE: if (btn_store) begin
          w_wstate_nxt = WSTORE;
          w_wcnt_nxt   = '0;
        end else if (btn_next ^ btn_prev) begin
          w_wstate_nxt = WLOAD;
        end
        WSTORE: if (r_wcnt == W_LAST) begin
          w_wstate_nxt = WIDLE;
          w_wcnt_nxt   = '0;
        end else begin
          w_wcnt_nxt = r_wcnt + WCW'(1);
        end
        default: w_wstate_nxt = WIDLE;
      endcase
    end
  end

  // reset_n gates write so a store interrupted by reset drops the strobe immediately
  always_comb begin
    write        = prog && reset_n && (r_wstate == WSTORE);
    w_store_done = prog && (r_wstate == WSTORE) && (r_wcnt == W_LAST);
    w_step_next  = prog && (r_wstate == WIDLE) && !btn_store && btn_next && !btn_prev;
    w_step_prev  = prog && (r_wstate == WIDLE) && !btn_store && btn_prev && !btn_next;
    w_load       = prog && (r_wstate == WLOAD);
    w_key_act    = prog && clken && (r_kstate == KPRESS) && (key_value == r_klatch)
                   && (r_kcnt == K_LAST) && (r_wstate == WIDLE);
  end

  always_comb begin
    w_onehot = 1'b1;
    w_nib    = 4'h0;
    case (r_klatch)
      16'h8000: w_nib = 4'h1;
      16'h4000: w_nib = 4'h2;
      16'h2000: w_nib = 4'h3;
      16'h1000: w_nib = 4'hA;
      16'h0800: w_nib = 4'h4;
      16'h0400: w_nib = 4'h5;
      16'h0200: w_nib = 4'h6;
      16'h0100: w_nib = 4'hB;
      16'h0080: w_nib = 4'h7;
      16'h0040: w_nib = 4'h8;
      16'h0020: w_nib = 4'h9;
      16'h0010: w_nib = 4'hC;
      16'h0008: w_nib = 4'h0;
      16'h0004: w_nib = 4'hF;
      16'h0002: w_nib = 4'hE;
      16'h0001: w_nib = 4'hD;
      default:  w_onehot = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_adr     <= '0;
      r_data    <= '0;
      r_digits  <= '0;
      r_key_err <= 1'b0;
    end else begin
      if (w_store_done) begin
        r_digits  <= '0;
        r_key_err <= 1'b0;
        if (AUTO_INC != 0) r_adr <= r_adr + 4'd1;
      end else if (w_step_next) begin
        r_adr <= r_adr + 4'd1;
      end else if (w_step_prev) begin
        r_adr <= r_adr - 4'd1;
      end
      if (w_load) begin
        r_data    <= mem_rdata;
        r_digits  <= '0;
        r_key_err <= 1'b0;
      end else if (w_key_act) begin
        if (w_onehot) begin
          r_data   <= {r_data[3:0], w_nib};
          r_digits <= (r_digits == 2'd2) ? 2'd2 : r_digits + 2'd1;
        end else begin
          r_key_err <= 1'b1;
        end
      end
    end
  end

  assign adr     = r_adr;
  assign data    = r_data;
  assign digits  = r_digits;
  assign key_err = r_key_err;

endmodule

// File: tb/tb_hexpad_loader.sv
// tb/tb_hexpad_loader.sv - randomized self-checking bench for hexpad_loader against an operation-level model
module tb_hexpad_loader;

  logic        clk = 1'b0;
  logic        reset_n, clken, prog;
  logic [15:0] key_value;
  logic        btn_next, btn_prev, btn_store;
  logic [7:0]  mem_rdata;
  logic [3:0]  adr;
  logic [7:0]  data;
  logic        write;
  logic [1:0]  digits;
  logic        key_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] mem   [16];
  logic [7:0] m_mem [16];
  logic [3:0] m_adr;
  logic [7:0] m_data;
  logic [1:0] m_digits;
  logic       m_err;
  logic [3:0] kmap  [16] = '{4'hD, 4'hE, 4'hF, 4'h0, 4'hC, 4'h9, 4'h8, 4'h7,
                             4'hB, 4'h6, 4'h5, 4'h4, 4'hA, 4'h3, 4'h2, 4'h1};

  hexpad_loader dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .prog(prog), .key_value(key_value),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_store(btn_store), .mem_rdata(mem_rdata),
    .adr(adr), .data(data), .write(write), .digits(digits), .key_err(key_err)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[adr];
  always @(posedge clk) if (write) mem[adr] <= data;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_adr"}, 16'(adr), 16'(m_adr));
    check({tag, "_data"}, 16'(data), 16'(m_data));
    check({tag, "_digits"}, 16'(digits), 16'(m_digits));
    check({tag, "_key_err"}, 16'(key_err), 16'(m_err));
  endtask

  task automatic tick();
    clken = 1'b1;
    @(negedge clk);
    clken = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic model_key(input logic [15:0] vec);
    logic [3:0] nib;
    nib = 4'h0;
    if ($countones(vec) == 1) begin
      for (int i = 0; i < 16; i++) if (vec[i]) nib = kmap[i];
      m_data = {m_data[3:0], nib};
      if (m_digits < 2'd2) m_digits = m_digits + 2'd1;
    end else begin
      m_err = 1'b1;
    end
  endtask

  task automatic key(input logic [15:0] vec, input string tag);
    key_value = vec;
    repeat (5) tick();
    key_value = '0;
    repeat (5) tick();
    if (prog) model_key(vec);
    check_all(tag);
  endtask

  task automatic step(input logic nxt, input logic prv, input string tag);
    logic [7:0] old_data;
    old_data  = m_data;
    btn_next  = nxt;
    btn_prev  = prv;
    @(negedge clk);
    btn_next  = 1'b0;
    btn_prev  = 1'b0;
    if (prog && (nxt ^ prv)) begin
      m_adr = nxt ? m_adr + 4'd1 : m_adr - 4'd1;
      check({tag, "_adr_p1"}, 16'(adr), 16'(m_adr));
      check({tag, "_data_p1"}, 16'(data), 16'(old_data));
      @(negedge clk);
      m_data   = m_mem[m_adr];
      m_digits = 2'd0;
      m_err    = 1'b0;
    end else begin
      repeat (3) @(negedge clk);
    end
    check_all(tag);
  endtask

  task automatic store(input string tag);
    int         hi;
    int         first;
    logic [3:0] a0;
    hi    = 0;
    first = -1;
    a0    = m_adr;
    check({tag, "_wr_before"}, 16'(write), 16'd0);
    btn_store = 1'b1;
    @(negedge clk);
    btn_store = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (write) begin
        hi++;
        if (first < 0) first = i;
        check({tag, "_wr_adr"}, 16'(adr), 16'(a0));
        check({tag, "_wr_data"}, 16'(data), 16'(m_data));
      end
      @(negedge clk);
    end
    check({tag, "_wr_len"}, 16'(hi), 16'd2);
    check({tag, "_wr_start"}, 16'(first), 16'd0);
    m_mem[a0] = m_data;
    m_adr     = m_adr + 4'd1;
    m_digits  = 2'd0;
    m_err     = 1'b0;
    check({tag, "_mem"}, 16'(mem[a0]), 16'(m_mem[a0]));
    check_all(tag);
  endtask

  initial begin
    reset_n = 1'b0; clken = 1'b0; prog = 1'b1; key_value = '0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_store = 1'b0;
    for (int i = 0; i < 16; i++) begin
      mem[i]   = 8'($urandom);
      m_mem[i] = mem[i];
    end
    m_adr = '0; m_data = '0; m_digits = '0; m_err = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_write", 16'(write), 16'd0);
    check_all("reset");
    reset_n = 1'b1;
    @(negedge clk);

    key(16'h8000, "key_1");
    key(16'h0004, "key_F");
    check("key_1F", 16'(data), 16'h1F);
    key(16'h1000, "key_A");
    check("key_FA", 16'(data), 16'hFA);
    check("digits_sat", 16'(digits), 16'd2);

    for (int i = 0; i < 6; i++) begin
      key_value = (i % 2 == 0) ? 16'h0800 : 16'h0000;
      tick();
    end
    key_value = 16'h0800;
    repeat (4) tick();
    key_value = '0;
    repeat (5) tick();
    model_key(16'h0800);
    check("bounce_nib", 16'(data[3:0]), 16'h4);
    check_all("bounce");

    key(16'h8001, "key_err");
    check("key_err_set", 16'(key_err), 16'd1);

    step(1'b0, 1'b1, "prev_wrap");
    check("prev_wrap_F", 16'(adr), 16'hF);
    step(1'b1, 1'b0, "next_wrap");
    step(1'b1, 1'b1, "both");

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, "to5");
    key(16'h2000, "key_3");
    key(16'h0010, "key_C");
    check("data_3C", 16'(data), 16'h3C);
    store("store5");
    check("store5_adr6", 16'(adr), 16'h6);

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "toF");
    store("storeF");
    check("storeF_wrap", 16'(adr), 16'h0);

    prog = 1'b0;
    key(16'h0100, "noprog_key");
    step(1'b1, 1'b0, "noprog_next");
    prog = 1'b1;
    @(negedge clk);

    btn_store = 1'b1;
    @(negedge clk);
    btn_store = 1'b0;
    check("abort_wr_hi", 16'(write), 16'd1);
    prog = 1'b0;
    #1;
    check("abort_wr_drop", 16'(write), 16'd0);
    @(negedge clk);
    prog = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_wr_low", 16'(write), 16'd0);
    check("abort_mem", 16'(mem[m_adr]), 16'(m_mem[m_adr]));
    check_all("abort");

    for (int n = 0; n < 30; n++) begin
      int op;
      int a;
      int b;
      op = $urandom_range(0, 6);
      a  = $urandom_range(0, 15);
      b  = (a + 1 + $urandom_range(0, 14)) % 16;
      case (op)
        0, 1: key(16'(1) << a, "rnd_key");
        2:    key((16'(1) << a) | (16'(1) << b), "rnd_bad");
        3:    step(1'b1, 1'b0, "rnd_next");
        4:    step(1'b0, 1'b1, "rnd_prev");
        5:    store("rnd_store");
        default: step(1'b1, 1'b1, "rnd_both");
      endcase
    end

    btn_store = 1'b1;
    @(negedge clk);
    btn_store = 1'b0;
    reset_n   = 1'b0;
    #1;
    check("rst_store_wr", 16'(write), 16'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_adr = '0; m_data = '0; m_digits = '0; m_err = 1'b0;
    @(negedge clk);
    check("rst_store_wr2", 16'(write), 16'd0);
    check_all("rst_store");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
